// File: rtl/jtvigil_sndlatch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | jtvigil_sndlatch                                                         |
// | Main-to-sound command latch with Z80 IM0 vector merge (latch + YM2151).  |
// | Option: JTVIGIL_LATCH_FIFO_EN selects a 2-entry FIFO over a single reg.  |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module jtvigil_sndlatch (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] main_dout,
  input  logic       latch_wr,
  input  logic       latch_rd,
  input  logic       irq_ack,
  input  logic       fm_irqn,
  output logic [7:0] snd_latch,
  output logic       int_n,
  output logic [7:0] int_vector,
  output logic [1:0] pending,
  output logic       overflow
);

  logic       r_wr_q;
  logic       r_rd_q;
  logic       r_ack_q;
  logic       r_fm_irqn_q;
  logic       w_push;
  logic       w_pop;
  logic       w_dbg_rd_unused;
  logic [7:0] r_head;
  logic       w_latch_pend;
  logic       w_fm_pend;
  logic       r_int_n;
  logic [7:0] r_int_vector;

  // Edge registers come out of reset high so a strobe held through reset is not an event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_q      <= 1'b1;
      r_rd_q      <= 1'b1;
      r_ack_q     <= 1'b1;
      r_fm_irqn_q <= 1'b1;
    end else begin
      r_wr_q      <= latch_wr;
      r_rd_q      <= latch_rd;
      r_ack_q     <= irq_ack;
      r_fm_irqn_q <= fm_irqn;
    end
  end

  assign w_push          = latch_wr & ~r_wr_q;
  assign w_pop           = irq_ack  & ~r_ack_q;
  assign w_dbg_rd_unused = latch_rd & ~r_rd_q;

`ifdef JTVIGIL_LATCH_FIFO_EN
  logic [7:0] r_tail;
  logic [1:0] r_count;
  logic       r_overflow;
  logic [7:0] w_head_nx;
  logic [7:0] w_tail_nx;
  logic [1:0] w_count_nx;
  logic       w_ovf_nx;

  // Pop is applied before push, so a full FIFO can accept on the same cycle it drains
  always_comb begin
    w_head_nx  = r_head;
    w_tail_nx  = r_tail;
    w_count_nx = r_count;
    w_ovf_nx   = r_overflow;
    case (r_count)
      2'd0: begin
        if (w_push) begin
          w_head_nx  = main_dout;
          w_count_nx = 2'd1;
        end
      end
      2'd1: begin
        case ({w_push, w_pop})
          2'b10: begin
            w_tail_nx  = main_dout;
            w_count_nx = 2'd2;
          end
          2'b01: w_count_nx = 2'd0;
          2'b11: w_head_nx  = main_dout;
          default: ;
        endcase
      end
      default: begin
        case ({w_push, w_pop})
          2'b10: w_ovf_nx = 1'b1;
          2'b01: begin
            w_head_nx  = r_tail;
            w_count_nx = 2'd1;
          end
          2'b11: begin
            w_head_nx = r_tail;
            w_tail_nx = main_dout;
          end
          default: ;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head     <= 8'h00;
      r_tail     <= 8'h00;
      r_count    <= 2'd0;
      r_overflow <= 1'b0;
    end else begin
      r_head     <= w_head_nx;
      r_tail     <= w_tail_nx;
      r_count    <= w_count_nx;
      r_overflow <= w_ovf_nx;
    end
  end

  assign pending  = r_count;
  assign overflow = r_overflow;
`else
  logic r_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= 8'h00;
      r_pend <= 1'b0;
    end else begin
      if (w_push) begin
        r_head <= main_dout;
        r_pend <= 1'b1;
      end else if (w_pop) begin
        r_pend <= 1'b0;
      end
    end
  end

  assign pending  = {1'b0, r_pend};
  assign overflow = 1'b0;
`endif

  assign snd_latch    = r_head;
  assign w_latch_pend = |pending;
  assign w_fm_pend    = ~r_fm_irqn_q;

  // Bit 5 low selects RST 18h, bit 3 low selects RST 30h; both low gives RST 10h
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_int_n      <= 1'b1;
      r_int_vector <= 8'hFF;
    end else begin
      r_int_n      <= ~(w_latch_pend | w_fm_pend);
      r_int_vector <= {2'b11, ~w_latch_pend, 1'b1, ~w_fm_pend, 3'b111};
    end
  end

  assign int_n      = r_int_n;
  assign int_vector = r_int_vector;

endmodule
`default_nettype wire

// File: tb/tb_jtvigil_sndlatch.sv
`default_nettype none
// Bench for jtvigil_sndlatch: directed scenarios plus random traffic against a
// queue-based reference model. Honours JTVIGIL_LATCH_FIFO_EN like the design.
module tb_jtvigil_sndlatch;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] main_dout;
  logic       latch_wr;
  logic       latch_rd;
  logic       irq_ack;
  logic       fm_irqn;
  logic [7:0] snd_latch;
  logic       int_n;
  logic [7:0] int_vector;
  logic [1:0] pending;
  logic       overflow;

  jtvigil_sndlatch dut (
    .clk        (clk),
    .rst        (rst),
    .main_dout  (main_dout),
    .latch_wr   (latch_wr),
    .latch_rd   (latch_rd),
    .irq_ack    (irq_ack),
    .fm_irqn    (fm_irqn),
    .snd_latch  (snd_latch),
    .int_n      (int_n),
    .int_vector (int_vector),
    .pending    (pending),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

`ifdef JTVIGIL_LATCH_FIFO_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] mq[$];
  logic [7:0] m_last;
  logic       m_ovf;
  logic       m_fm;
  logic       m_int_n;
  logic [7:0] m_vec;
  logic       p_wr;
  logic       p_ack;

  function automatic void model_reset();
    mq.delete();
    m_last  = 8'h00;
    m_ovf   = 1'b0;
    m_fm    = 1'b0;
    m_int_n = 1'b1;
    m_vec   = 8'hFF;
    p_wr    = 1'b1;
    p_ack   = 1'b1;
  endfunction

  function automatic void model_clock();
    logic push, pop;
    // Interrupt outputs lag the pending state by one clock
    m_int_n = !((mq.size() != 0) || m_fm);
    m_vec   = 8'hFF;
    if (mq.size() != 0) m_vec = m_vec - 8'h20;
    if (m_fm)           m_vec = m_vec - 8'h08;
    m_fm = !fm_irqn;
    push = latch_wr && !p_wr;
    pop  = irq_ack && !p_ack;
    if (pop && mq.size() > 0) m_last = mq.pop_front();
    if (push) begin
      if (DEPTH == 1) mq.delete();
      if (mq.size() < DEPTH) mq.push_back(main_dout);
      else m_ovf = 1'b1;
    end
    p_wr  = latch_wr;
    p_ack = irq_ack;
  endfunction

  function automatic logic [7:0] m_snd();
    return (mq.size() != 0) ? mq[0] : m_last;
  endfunction

  function automatic logic [1:0] m_pend();
    return 2'(mq.size());
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_clock();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; latch_wr = 1'b0; latch_rd = 1'b0; irq_ack = 1'b0; fm_irqn = 1'b1;
    main_dout = 8'h00;
    repeat (3) step();
    rst = 1'b0;
    step();
  endtask

  task automatic write_byte(input logic [7:0] d);
    main_dout = d; latch_wr = 1'b1; step();
    latch_wr = 1'b0; step();
  endtask

  task automatic ack_once();
    irq_ack = 1'b1; step();
    irq_ack = 1'b0; step();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (snd_latch !== 8'h00) begin bad++; $display("FAIL reset_snd: got %h want 00", snd_latch); end
    total++; if (int_n !== 1'b1) begin bad++; $display("FAIL reset_int_n: got %b want 1", int_n); end
    total++; if (int_vector !== 8'hFF) begin bad++; $display("FAIL reset_vec: got %h want FF", int_vector); end
    total++; if (pending !== 2'd0) begin bad++; $display("FAIL reset_pend: got %0d want 0", pending); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", overflow); end
  endtask

  task automatic test_single_write();
    do_reset();
    main_dout = 8'h3A; latch_wr = 1'b1; step();
    latch_wr = 1'b0;
    total++; if (snd_latch !== 8'h3A) begin bad++; $display("FAIL wr_snd: got %h want 3A", snd_latch); end
    total++; if (pending !== 2'd1) begin bad++; $display("FAIL wr_pend: got %0d want 1", pending); end
    total++; if (int_n !== 1'b1) begin bad++; $display("FAIL wr_int_early: got %b want 1", int_n); end
    step();
    total++; if (int_n !== 1'b0) begin bad++; $display("FAIL wr_int_n: got %b want 0", int_n); end
    total++; if (int_vector !== 8'hDF) begin bad++; $display("FAIL wr_vec: got %h want DF", int_vector); end
    ack_once();
    total++; if (int_n !== 1'b1) begin bad++; $display("FAIL ack_int_n: got %b want 1", int_n); end
    total++; if (int_vector !== 8'hFF) begin bad++; $display("FAIL ack_vec: got %h want FF", int_vector); end
    total++; if (snd_latch !== 8'h3A) begin bad++; $display("FAIL ack_snd: got %h want 3A", snd_latch); end
    total++; if (pending !== 2'd0) begin bad++; $display("FAIL ack_pend: got %0d want 0", pending); end
  endtask

  task automatic test_fifo();
    do_reset();
    write_byte(8'h11); write_byte(8'h22); write_byte(8'h33);
    total++; if (pending !== m_pend()) begin bad++; $display("FAIL fifo_pend: got %0d want %0d", pending, m_pend()); end
    total++; if (overflow !== m_ovf) begin bad++; $display("FAIL fifo_ovf: got %b want %b", overflow, m_ovf); end
    total++; if (snd_latch !== m_snd()) begin bad++; $display("FAIL fifo_head: got %h want %h", snd_latch, m_snd()); end
`ifdef JTVIGIL_LATCH_FIFO_EN
    total++; if (pending !== 2'd2 || overflow !== 1'b1 || snd_latch !== 8'h11) begin
      bad++; $display("FAIL fifo_full: got pend=%0d ovf=%b snd=%h want 2 1 11", pending, overflow, snd_latch); end
    ack_once();
    total++; if (snd_latch !== 8'h22) begin bad++; $display("FAIL fifo_pop1: got %h want 22", snd_latch); end
    ack_once();
    total++; if (pending !== 2'd0 || snd_latch !== 8'h22) begin
      bad++; $display("FAIL fifo_pop2: got pend=%0d snd=%h want 0 22", pending, snd_latch); end
`else
    total++; if (pending !== 2'd1 || overflow !== 1'b0 || snd_latch !== 8'h33) begin
      bad++; $display("FAIL single_over: got pend=%0d ovf=%b snd=%h want 1 0 33", pending, overflow, snd_latch); end
    ack_once();
    total++; if (pending !== 2'd0 || snd_latch !== 8'h33) begin
      bad++; $display("FAIL single_pop: got pend=%0d snd=%h want 0 33", pending, snd_latch); end
`endif
  endtask

  task automatic test_hold();
    do_reset();
    main_dout = 8'h55; latch_wr = 1'b1;
    repeat (10) step();
    latch_wr = 1'b0; step();
    total++; if (pending !== 2'd1 || snd_latch !== 8'h55) begin
      bad++; $display("FAIL hold_push: got pend=%0d snd=%h want 1 55", pending, snd_latch); end
  endtask

  task automatic test_fm_merge();
    do_reset();
    write_byte(8'h01);
    fm_irqn = 1'b0; step(); step();
    total++; if (int_vector !== 8'hD7 || int_n !== 1'b0) begin
      bad++; $display("FAIL fm_both: got vec=%h int_n=%b want D7 0", int_vector, int_n); end
    ack_once(); step();
    total++; if (int_vector !== 8'hF7 || int_n !== 1'b0) begin
      bad++; $display("FAIL fm_only: got vec=%h int_n=%b want F7 0", int_vector, int_n); end
    fm_irqn = 1'b1; step();
    total++; if (int_n !== 1'b0) begin bad++; $display("FAIL fm_release_early: got %b want 0", int_n); end
    step();
    total++; if (int_n !== 1'b1 || int_vector !== 8'hFF) begin
      bad++; $display("FAIL fm_release: got int_n=%b vec=%h want 1 FF", int_n, int_vector); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    main_dout = 8'hB0; latch_wr = 1'b1; irq_ack = 1'b1; step();
    latch_wr = 1'b0; irq_ack = 1'b0; step();
    total++; if (pending !== 2'd1 || snd_latch !== 8'hB0) begin
      bad++; $display("FAIL empty_pushpop: got pend=%0d snd=%h want 1 B0", pending, snd_latch); end
    do_reset();
    write_byte(8'hA0); write_byte(8'hA1);
    main_dout = 8'hA2; latch_wr = 1'b1; irq_ack = 1'b1; step();
    latch_wr = 1'b0; irq_ack = 1'b0;
    total++; if (snd_latch !== m_snd() || pending !== m_pend() || overflow !== m_ovf) begin
      bad++; $display("FAIL full_pushpop: got snd=%h pend=%0d ovf=%b want %h %0d %b",
                      snd_latch, pending, overflow, m_snd(), m_pend(), m_ovf); end
`ifdef JTVIGIL_LATCH_FIFO_EN
    total++; if (snd_latch !== 8'hA1 || pending !== 2'd2 || overflow !== 1'b0) begin
      bad++; $display("FAIL full_pushpop_lit: got snd=%h pend=%0d ovf=%b want A1 2 0", snd_latch, pending, overflow); end
`endif
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    write_byte(8'hC0); write_byte(8'hC1);
    main_dout = 8'hC2; latch_wr = 1'b1; step();
    rst = 1'b1; model_reset(); #1;
    total++; if (snd_latch !== 8'h00 || pending !== 2'd0 || overflow !== 1'b0 || int_n !== 1'b1 || int_vector !== 8'hFF) begin
      bad++; $display("FAIL rst_mid: got snd=%h pend=%0d ovf=%b int_n=%b vec=%h want 00 0 0 1 FF",
                      snd_latch, pending, overflow, int_n, int_vector); end
    repeat (2) step();
    rst = 1'b0;
    repeat (4) step();
    total++; if (pending !== 2'd0 || int_n !== 1'b1) begin
      bad++; $display("FAIL rst_held_wr: got pend=%0d int_n=%b want 0 1", pending, int_n); end
    latch_wr = 1'b0; step();
    latch_wr = 1'b1; step();
    total++; if (pending !== 2'd1 || snd_latch !== 8'hC2) begin
      bad++; $display("FAIL rst_toggle_push: got pend=%0d snd=%h want 1 C2", pending, snd_latch); end
    latch_wr = 1'b0; step();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      main_dout = 8'($urandom);
      latch_wr  = ($urandom_range(0, 2) == 0);
      irq_ack   = ($urandom_range(0, 3) == 0);
      latch_rd  = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 15) == 0) fm_irqn = ~fm_irqn;
      step();
      total++; if (snd_latch !== m_snd()) begin bad++; $display("FAIL rnd_snd[%0d]: got %h want %h", i, snd_latch, m_snd()); end
      total++; if (pending !== m_pend()) begin bad++; $display("FAIL rnd_pend[%0d]: got %0d want %0d", i, pending, m_pend()); end
      total++; if (overflow !== m_ovf) begin bad++; $display("FAIL rnd_ovf[%0d]: got %b want %b", i, overflow, m_ovf); end
      total++; if (int_n !== m_int_n) begin bad++; $display("FAIL rnd_int_n[%0d]: got %b want %b", i, int_n, m_int_n); end
      total++; if (int_vector !== m_vec) begin bad++; $display("FAIL rnd_vec[%0d]: got %h want %h", i, int_vector, m_vec); end
    end
  endtask

  initial begin
    rst = 1'b1; latch_wr = 1'b0; latch_rd = 1'b0; irq_ack = 1'b0; fm_irqn = 1'b1; main_dout = 8'h00;
    model_reset();
    test_reset();
    test_single_write();
    test_fifo();
    test_hold();
    test_fm_merge();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
`default_nettype wire
